regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk_i, input, 1 bit, sole clock, rising edge.
REQ-006 SHALL have port rst_n_i, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port raddr_i, input, NUM_RD*ADDR_W bits, packed read addresses; port k at [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rdata_o, output, NUM_RD*DATA_W bits, packed registered read data; port k at [k*DATA_W +: DATA_W].
REQ-009 SHALL have port waddr_i, input, ADDR_W bits, write address.
REQ-010 SHALL have port wdata_i, input, DATA_W bits, write data.
REQ-011 SHALL have port wen_i, input, 1 bit, write enable.
REQ-012 SHALL have port clr_i, input, 1 bit, clear-all request, single-cycle pulse.
REQ-013 SHALL have port busy_o, output, 1 bit, high while clear sweep is in progress.

Function
REQ-014 SHALL write wdata_i to entry waddr_i on the rising edge when wen_i=1, busy_o=0 and clr_i=0.
REQ-015 SHALL hard-wire entry 0 to zero: writes to address 0 are discarded; reads of address 0 return 0.
REQ-016 SHALL register every read port: rdata_o port k at edge N+1 reflects raddr_i port k sampled at edge N; latency exactly 1 cycle.
REQ-017 SHALL serve all read ports independently; identical addresses on several ports return identical data.
REQ-018 SHALL implement an FSM with states IDLE and CLEAR.
REQ-019 IDLE -> CLEAR when clr_i=1; a write presented in the same cycle is dropped (clear wins).
REQ-020 In CLEAR, SHALL zero one entry per cycle, index 0 to DEPTH-1 ascending, using an ADDR_W-bit sweep counter.
REQ-021 CLEAR -> IDLE after writing entry DEPTH-1; busy_o high for exactly DEPTH cycles, starting the cycle after the clr_i edge.
REQ-022 SHALL ignore wen_i while busy_o=1 (writes are lost, not queued).
REQ-023 SHALL ignore clr_i while busy_o=1; the sweep does not restart.
REQ-024 Reads during CLEAR SHALL return current array contents; entries not yet swept hold old values.
REQ-025 A read of the entry being swept in the same cycle SHALL return its pre-clear value.

Reset
REQ-026 On rst_n_i=0, SHALL asynchronously zero all DEPTH entries, all rdata_o bits, and the sweep counter, and force state IDLE with busy_o=0.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep; after release the block is IDLE with all entries zero.
REQ-028 SHALL perform no write or clear on the first edge after release unless wen_i or clr_i is asserted.

Configuration
REQ-029 Macro REGFILE_MP_BYPASS_EN SHALL select write-to-read forwarding.
REQ-030 With REGFILE_MP_BYPASS_EN defined: when a write is accepted at edge N to address A!=0 and read port k samples A at edge N, rdata_o port k after edge N SHALL equal wdata_i.
REQ-031 Without REGFILE_MP_BYPASS_EN: the same case SHALL return the value held before the write; the new value is visible from the next read.

Verification
REQ-032 Reset, then read all addresses on all ports -> every rdata_o equals 0 one cycle after each address is applied.
REQ-033 Write 0xDEADBEEF to addr 7; next cycle read addr 7 on port 0 and port 1 -> both return 0xDEADBEEF after 1 cycle; write 0x1234 to addr 0 -> addr 0 reads 0.
REQ-034 Same-cycle write 0xA5A5A5A5 to addr 3 and read addr 3 (old value 0x11) -> 0xA5A5A5A5 with REGFILE_MP_BYPASS_EN, 0x11 without.
REQ-035 Fill entries 1..31 with their index; pulse clr_i -> busy_o high exactly 32 cycles; wen_i during sweep has no effect; afterwards all reads return 0.
REQ-036 Pulse clr_i together with a write of 0x55 to addr 9 -> write dropped, addr 9 reads 0 after sweep; second clr_i during sweep -> busy_o still drops after 32 cycles.
REQ-037 Assert rst_n_i low at sweep cycle 10 -> busy_o and rdata_o go to 0 immediately, no clock needed; after release, all entries read 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with entry 0 hard-wired to zero and a one-entry-per-cycle clear sweep.
// Optional write-to-read forwarding is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdata_o,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     wen_i,
    input  logic                     clr_i,
    output logic                     busy_o
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_W;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   sweep_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_q [NUM_RD];
    logic                wr_acc_c;

    // A clear request or an active sweep always takes precedence over a write.
    assign wr_acc_c = wen_i && !busy_o && !clr_i && (waddr_i != '0);

    // Clear-sweep control: busy_o tracks the CLEAR state as a registered flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            sweep_q <= '0;
            busy_o  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_i) begin
                        state_q <= CLEAR;
                        sweep_q <= '0;
                        busy_o  <= 1'b1;
                    end
                end
                CLEAR: begin
                    sweep_q <= sweep_q + ADDR_W'(1);
                    if (sweep_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: sweep zeroing or an accepted write, never both.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (busy_o) begin
            mem[sweep_q] <= '0;
        end else if (wr_acc_c) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
        if (ra == '0) begin
            return '0;
        end else if (BYPASS_EN && wr_acc_c && (waddr_i == ra)) begin
            return wdata_i;
        end else begin
            return mem[ra];
        end
    endfunction

    // Registered read ports; the array value seen is the pre-edge content.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned k = 0; k < NUM_RD; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_RD; k++) begin
                rd_q[k] <= read_port(raddr_i[k*ADDR_W +: ADDR_W]);
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_pack
        assign rdata_o[g*DATA_W +: DATA_W] = rd_q[g];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned RA_W   = NUM_RD * ADDR_W;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                     clk_i = 1'b0;
    logic                     rst_n_i = 1'b0;
    logic [RA_W-1:0]          raddr_i = '0;
    logic [NUM_RD*DATA_W-1:0] rdata_o;
    logic [ADDR_W-1:0]        waddr_i = '0;
    logic [DATA_W-1:0]        wdata_i = '0;
    logic                     wen_i = 1'b0;
    logic                     clr_i = 1'b0;
    logic                     busy_o;

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .raddr_i (raddr_i),
        .rdata_o (rdata_o),
        .waddr_i (waddr_i),
        .wdata_i (wdata_i),
        .wen_i   (wen_i),
        .clr_i   (clr_i),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: plain contents array, busy flag and next sweep index.
    logic [DATA_W-1:0] model [DEPTH];
    bit                m_busy = 1'b0;
    int unsigned       m_idx = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] port_data(input int unsigned k);
        return rdata_o[k*DATA_W +: DATA_W];
    endfunction

    function automatic logic [ADDR_W-1:0] port_addr(input int unsigned k);
        return raddr_i[k*ADDR_W +: ADDR_W];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        m_busy = 1'b0;
        m_idx  = 0;
    endtask

    // One clock: predict from pre-edge state, advance the model, then compare.
    task automatic step();
        logic [DATA_W-1:0] exp_rd [NUM_RD];
        bit                wacc;
        wacc = wen_i && !m_busy && !clr_i && (waddr_i != 0);
        for (int k = 0; k < int'(NUM_RD); k++) begin
            if (port_addr(k) == 0)
                exp_rd[k] = '0;
            else if (BYPASS && wacc && (waddr_i == port_addr(k)))
                exp_rd[k] = wdata_i;
            else
                exp_rd[k] = model[port_addr(k)];
        end
        @(posedge clk_i);
        if (m_busy) begin
            model[m_idx] = '0;
            m_idx++;
            if (m_idx == DEPTH) m_busy = 1'b0;
        end else if (clr_i) begin
            m_busy = 1'b1;
            m_idx  = 0;
        end else if (wacc) begin
            model[waddr_i] = wdata_i;
        end
        #1;
        check("busy", DATA_W'(busy_o), DATA_W'(m_busy));
        for (int k = 0; k < int'(NUM_RD); k++)
            check($sformatf("rd_p%0d_a%0d", k, port_addr(k)), port_data(k), exp_rd[k]);
    endtask

    task automatic idle_inputs();
        wen_i = 1'b0;
        clr_i = 1'b0;
    endtask

    task automatic set_raddr(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        raddr_i[0 +: ADDR_W]      = a0;
        raddr_i[ADDR_W +: ADDR_W] = a1;
    endtask

    task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wen_i = 1'b1; waddr_i = a; wdata_i = d;
        step();
        idle_inputs();
    endtask

    task automatic read_all();
        for (int a = 0; a < int'(DEPTH); a++) begin
            set_raddr(ADDR_W'(a), ADDR_W'(DEPTH - 1 - a));
            step();
            check("all_zero_p0", port_data(0), '0);
        end
    endtask

    // Counts busy cycles after a clear pulse, issuing random writes during the sweep.
    task automatic clear_and_count(input bit second_clr, output int cnt);
        int guard;
        cnt = 0;
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        guard = 0;
        while (busy_o && guard < 60) begin
            cnt++;
            guard++;
            wen_i   = 1'($urandom);
            waddr_i = ADDR_W'($urandom);
            wdata_i = $urandom;
            clr_i   = second_clr && (cnt == 5);
            raddr_i = RA_W'($urandom);
            step();
        end
        idle_inputs();
        if (guard >= 60) check("sweep_timeout", DATA_W'(guard), 32'd0);
    endtask

    initial begin
        int cnt;
        model_reset();
        #2;
        check("rst_busy", DATA_W'(busy_o), '0);
        check("rst_rd0", port_data(0), '0);
        check("rst_rd1", port_data(1), '0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Post-reset reads of every address on every port.
        read_all();

        // Basic write/read and the zero register.
        write(5'd7, 32'hDEADBEEF);
        set_raddr(5'd7, 5'd7);
        step();
        check("rd7_p0", port_data(0), 32'hDEADBEEF);
        check("rd7_p1", port_data(1), 32'hDEADBEEF);
        write(5'd0, 32'h0000_1234);
        set_raddr(5'd0, 5'd7);
        step();
        check("rd0_zero", port_data(0), '0);

        // Same-cycle write and read of one address.
        write(5'd3, 32'h11);
        set_raddr(5'd3, 5'd3);
        wen_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'hA5A5A5A5;
        step();
        idle_inputs();
        check("fwd_p0", port_data(0), BYPASS ? 32'hA5A5A5A5 : 32'h11);
        step();
        check("after_fwd_p1", port_data(1), 32'hA5A5A5A5);

        // Fill, then clear with writes attempted during the sweep.
        for (int a = 1; a < int'(DEPTH); a++) write(ADDR_W'(a), DATA_W'(a));
        set_raddr(5'd31, 5'd1);
        step();
        check("fill31", port_data(0), 32'd31);
        clear_and_count(1'b0, cnt);
        check("busy_len", DATA_W'(cnt), DATA_W'(DEPTH));
        read_all();

        // Clear with a coincident write, plus a second clear mid-sweep.
        write(5'd9, 32'h77);
        wen_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'h55;
        clear_and_count(1'b1, cnt);
        check("busy_len2", DATA_W'(cnt), DATA_W'(DEPTH));
        set_raddr(5'd9, 5'd9);
        step();
        check("rd9_dropped", port_data(0), '0);

        // Random traffic with occasional clears.
        for (int i = 0; i < 600; i++) begin
            raddr_i = RA_W'($urandom);
            wen_i   = ($urandom % 4) != 0;
            waddr_i = ADDR_W'($urandom);
            wdata_i = $urandom;
            clr_i   = ($urandom % 64) == 0;
            step();
        end
        idle_inputs();
        while (m_busy) step();

        // Asynchronous reset in the middle of a sweep.
        for (int a = 1; a < int'(DEPTH); a++) write(ADDR_W'(a), DATA_W'(a) | 32'h100);
        set_raddr(5'd20, 5'd30);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("mid_sweep_busy", DATA_W'(busy_o), 32'd1);
        check("mid_sweep_rd", port_data(0), 32'h114);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async_busy", DATA_W'(busy_o), '0);
        check("async_rd0", port_data(0), '0);
        check("async_rd1", port_data(1), '0);
        model_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        read_all();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
